// File: rtl/mult_share_sched.sv
// mult_share_sched
//   Round-robin scheduler that time-shares one combinational signed multiplier
//   among NUM_REQ requesters. The granted operand is registered onto mult_inp
//   and held for SETTLE_CYCLES clocks, because the multiplier path is slower
//   than one clock. The product is then captured and returned with the
//   requester id over a valid/ready handshake.
//
// Ports
//   clk, rst    clock (rising edge), asynchronous active-high reset
//   req_valid   per-requester operand valid
//   req_data    packed operands, requester k at [k*BIT_WIDTH +: BIT_WIDTH]
//   req_ready   one-hot grant, high only in IDLE
//   mult_inp    registered operand driving the shared multiplier
//   mult_out    multiplier product, combinational from mult_inp
//   rsp_valid   result valid (RESP state)
//   rsp_ready   result accepted by consumer
//   rsp_data    captured product, bit-exact copy of mult_out
//   rsp_id      index of the requester owning rsp_data
//   busy        scheduler not in IDLE
//   ops_done    completed result handshakes, saturating
module mult_share_sched #(
    parameter int BIT_WIDTH     = 5,
    parameter int OUT_WIDTH     = 2*BIT_WIDTH,
    parameter int NUM_REQ       = 4,
    parameter int ID_WIDTH      = $clog2(NUM_REQ),
    parameter int SETTLE_CYCLES = 3,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*BIT_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic [BIT_WIDTH-1:0]         mult_inp,
    input  logic [OUT_WIDTH-1:0]         mult_out,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [OUT_WIDTH-1:0]         rsp_data,
    output logic [ID_WIDTH-1:0]          rsp_id,
    output logic                         busy,
    output logic [CNT_WIDTH-1:0]         ops_done
);

    // Settle counter only has to hold SETTLE_CYCLES-1.
    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, SETTLE, RESP} state_t;

    state_t              state, state_nxt;
    logic [ID_WIDTH-1:0] last;     // most recently granted requester
    logic [ID_WIDTH-1:0] id;       // requester owning the op in flight
    logic [ID_WIDTH-1:0] gnt_idx;
    logic                gnt_vld;
    logic [SW-1:0]       cnt;

    // Round-robin search starting just after the last grant, wrapping.
    always_comb begin
        int                  k;
        logic [ID_WIDTH-1:0] kk;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        k       = 0;
        kk      = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            k  = (int'(last) + i) % NUM_REQ;
            kk = ID_WIDTH'(k);
            if (!gnt_vld && req_valid[kk]) begin
                gnt_vld = 1'b1;
                gnt_idx = kk;
            end
        end
    end

    // Grant is visible only while IDLE; requests seen in other states wait.
    always_comb begin
        req_ready = '0;
        if (state == IDLE && gnt_vld)
            req_ready[gnt_idx] = 1'b1;
    end

    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (gnt_vld)    state_nxt = SETTLE;
            SETTLE:  if (cnt == '0)  state_nxt = RESP;
            RESP:    if (rsp_ready)  state_nxt = IDLE;
            default:                 state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mult_inp <= '0;
            id       <= '0;
            last     <= ID_WIDTH'(NUM_REQ-1);  // requester 0 wins first
            cnt      <= '0;
            rsp_data <= '0;
            rsp_id   <= '0;
            ops_done <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_vld) begin
                        mult_inp <= req_data[int'(gnt_idx)*BIT_WIDTH +: BIT_WIDTH];
                        id       <= gnt_idx;
                        last     <= gnt_idx;
                        cnt      <= SW'(SETTLE_CYCLES-1);
                    end
                end
                SETTLE: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        rsp_data <= mult_out;
                        rsp_id   <= id;
                    end
                end
                RESP: begin
                    if (rsp_ready && ops_done != '1)
                        ops_done <= ops_done + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
